// File: rtl/gpu_pipe_pkg.sv
// Shared constants and helpers for GPU lane-balancing pipelines.
package gpu_pipe_pkg;

  // Standard lane delays used to size balancing pipes.
  localparam int RASTER_LAT  = 4;
  localparam int SHADE_LAT   = 6;
  localparam int MEM_RET_LAT = 12;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/data register pair of the elastic pipe; the top decides load/adv.
module elastic_pipe_stage
  import gpu_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clk_en) begin
      if (flush) begin
        v_d = 1'b0;
        if (CLEAR_DATA) d_d = '0;
      end else begin
        v_d = (v_q & ~adv_i) | load_i;
        if (load_i) d_d = d_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  // Data regs only carry a reset when they must read back as zero.
  if (CLEAR_DATA) begin : g_dclr
    always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= '0;
      else     d_q <= d_d;
    end
  end else begin : g_dkeep
    always_ff @(posedge clk) d_q <= d_d;
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/elastic_shift_pipe.sv
// DEPTH-stage elastic data+valid pipe with collapsing bubbles, flush and occupancy.
module elastic_shift_pipe
  import gpu_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter bit CLEAR_DATA = 1'b1,
  localparam int OW        = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);

  logic [DEPTH-1:0]            v, adv, load;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [OW-1:0]               occ_q, occ_d;
  logic                        xfer;

  // Stage i is stuck only if every stage ahead is valid and the sink isn't
  // taking; flattened so adv depends on v alone rather than on itself.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b1;
      for (int j = i + 1; j < DEPTH; j++) blocked = blocked & v[j];
      adv[i] = v[i] & clk_en & (out_ready | ~blocked);
    end
  end

  assign in_ready  = clk_en & ~flush & ~rst & (~v[0] | adv[0]);
  assign out_valid = v[DEPTH-1] & clk_en;
  assign out_data  = d[DEPTH-1];
  assign xfer      = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_head
      assign load[i] = in_valid & in_ready;
      assign d_in    = in_data;
    end else begin : g_body
      assign load[i] = adv[i-1];
      assign d_in    = d[i-1];
    end

    elastic_pipe_stage #(
      .WIDTH      (WIDTH),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .flush  (flush),
      .load_i (load[i]),
      .adv_i  (adv[i]),
      .d_i    (d_in),
      .v_o    (v[i]),
      .d_o    (d[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (clk_en) begin
      if (flush) occ_d = '0;
      else       occ_d = occ_q + OW'(load[0]) - OW'(xfer);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

  a_occ_range : assert property (@(posedge clk) disable iff (rst)
    (occ_q <= OW'(DEPTH)) && (occ_q == OW'($countones(v))));

endmodule

// File: tb/tb_elastic_shift_pipe.sv
// Bench for elastic_shift_pipe: DEPTH=4 and DEPTH=1 instances share stimulus.
module tb_elastic_shift_pipe;

  logic       clk = 1'b0;
  logic       rst, clk_en, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       in_ready4, out_valid4, in_ready1, out_valid1;
  logic [7:0] out_data4, out_data1;
  logic [2:0] occ4;
  logic [0:0] occ1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    int         exp_occ;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  elastic_shift_pipe #(.WIDTH(8), .DEPTH(4), .CLEAR_DATA(1'b1)) dut4 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occ4)
  );

  elastic_shift_pipe #(.WIDTH(8), .DEPTH(1), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Scoreboards: pushed on accepted input, popped on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      chk("rst_occ4", 32'(occ4), 0);
      chk("rst_ovld4", 32'(out_valid4), 0);
      chk("rst_irdy4", 32'(in_ready4), 0);
    end else begin
      chk("sb_occ4", 32'(occ4), q4.size());
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underrun4: got %0h expected no output", out_data4);
        end else chk("sb_data4", 32'(out_data4), 32'(q4.pop_front()));
      end
      if (in_valid && in_ready4) q4.push_back(in_data);
      if (clk_en && flush) q4.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      chk("rst_occ1", 32'(occ1), 0);
      chk("rst_ovld1", 32'(out_valid1), 0);
    end else begin
      chk("sb_occ1", 32'(occ1), q1.size());
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underrun1: got %0h expected no output", out_data1);
        end else chk("sb_data1", 32'(out_data1), 32'(q1.pop_front()));
      end
      if (in_valid && in_ready1) q1.push_back(in_data);
      if (clk_en && flush) q1.delete();
    end
  end

  initial begin
    // Backpressure vectors: fill four under stall, then release.
    tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 0, 8'h00};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1, 8'h00};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 2, 8'h00};
    tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 3, 8'h00};
    tbl[4]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 4, 8'h10};
    tbl[5]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 4, 8'h10};
    tbl[6]  = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 4, 8'h10};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4, 8'h11};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 8'h12};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 8'h13};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h14};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00};

    rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step(); step();
    settle();
    chk("reset_data4", 32'(out_data4), 0);
    chk("reset_data1", 32'(out_data1), 0);
    step();
    rst = 1'b0;

    // Latency: single word into empty pipes.
    for (int k = 0; k < 7; k++) begin
      in_valid = (k == 0); in_data = 8'hA5; out_ready = 1'b1;
      settle();
      chk("lat4_vld", 32'(out_valid4), 32'(k == 4));
      chk("lat4_occ", 32'(occ4), 32'(k >= 1 && k <= 4));
      if (k == 4) chk("lat4_data", 32'(out_data4), 32'hA5);
      chk("lat1_vld", 32'(out_valid1), 32'(k == 1));
      if (k == 1) chk("lat1_data", 32'(out_data1), 32'hA5);
      step();
    end

    // Streaming 0..15 back-to-back.
    for (int k = 0; k < 21; k++) begin
      in_valid = (k < 16); in_data = 8'(k); out_ready = 1'b1;
      settle();
      if (k < 16) chk("strm_irdy4", 32'(in_ready4), 1);
      chk("strm_vld4", 32'(out_valid4), 32'(k >= 4 && k < 20));
      if (k >= 4 && k < 20) chk("strm_data4", 32'(out_data4), 32'(k - 4));
      chk("strm_vld1", 32'(out_valid1), 32'(k >= 1 && k < 17));
      step();
    end

    // Backpressure table.
    for (int r = 0; r < 12; r++) begin
      in_valid = tbl[r].iv; in_data = tbl[r].id; out_ready = tbl[r].ordy;
      settle();
      chk($sformatf("bp%0d_irdy", r), 32'(in_ready4), 32'(tbl[r].exp_ir));
      chk($sformatf("bp%0d_vld", r), 32'(out_valid4), 32'(tbl[r].exp_ov));
      chk($sformatf("bp%0d_occ", r), 32'(occ4), tbl[r].exp_occ);
      if (tbl[r].exp_ov) chk($sformatf("bp%0d_data", r), 32'(out_data4), 32'(tbl[r].exp_d));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();

    // Bubble collapse under stall.
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k == 0 || k == 3); in_data = (k == 0) ? 8'h01 : 8'h02;
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("bub_occ", 32'(occ4), 2);
    chk("bub_irdy", 32'(in_ready4), 1);
    chk("bub_vld", 32'(out_valid4), 1);
    chk("bub_data", 32'(out_data4), 32'h01);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Flush then clock-enable freeze.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + k);
      step();
    end
    flush = 1'b1; in_data = 8'h23;
    settle();
    chk("fl_irdy", 32'(in_ready4), 0);
    chk("fl_occ_pre", 32'(occ4), 3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    chk("fl_occ", 32'(occ4), 0);
    chk("fl_vld", 32'(out_valid4), 0);
    chk("fl_irdy_after", 32'(in_ready4), 1);
    step();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + k);
      step();
    end
    clk_en = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 8'h40;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("cen_irdy", 32'(in_ready4), 0);
      chk("cen_vld", 32'(out_valid4), 0);
      chk("cen_occ", 32'(occ4), 2);
      step();
    end
    clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    settle();
    chk("cen_drain_occ", 32'(occ4), 0);
    step();

    // Async reset mid-stream.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + k);
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("ar_occ_pre", 32'(occ4), 3);
    step();
    rst = 1'b1;
    #1;
    chk("ar_vld", 32'(out_valid4), 0);
    chk("ar_occ", 32'(occ4), 0);
    chk("ar_data", 32'(out_data4), 0);
    chk("ar_irdy", 32'(in_ready4), 0);
    step();
    rst = 1'b0;
    step();

    // Post-reset sanity word through both depths.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h60;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    settle();
    chk("end_occ4", 32'(occ4), 0);
    chk("end_q4", q4.size(), 0);
    chk("end_q1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_shift_pipe.md
Name: elastic_shift_pipe

Overview:
- Parametrised successor to the fixed shift register: a DEPTH-stage, WIDTH-bit pipeline of data+valid with per-stage valid/ready backpressure.
- Bubbles collapse: a stage advances whenever the stage ahead is empty or itself advancing.
- Used to balance latency between GPU datapath lanes (rasteriser/shader/memory return) where the consumer can stall.
- Adds flush and occupancy reporting, and keeps a global clock enable.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 4, number of stages (>=1); also the minimum latency in cycles.
- CLEAR_DATA, 1, 1 = data regs reset and flush to 0; 0 = only valid bits cleared.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- clk_en  input  1  global enable; 0 freezes all state.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  pipe accepts this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  oldest word (stage DEPTH-1).
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State: v[i], d[i] for i=0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 is the output.
- Reset (async, rst=1): all v=0, occupancy=0, out_valid=0, in_ready=0 while rst is high. If CLEAR_DATA=1, all d=0 and out_data=0.
- Advance terms (combinational):
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready & clk_en.
  - adv[i] = v[i] & clk_en & (!v[i+1] | adv[i+1]).
- in_ready = clk_en & !flush & !rst & (!v[0] | adv[0]). The ready chain is combinational from out_ready through all stages; no registered ready.
- load[0] = in_valid & in_ready; load[i] = adv[i-1] for i>0.
- Next state (when clk_en=1 and flush=0): v[i] <= (v[i] & !adv[i]) | load[i]; d[i] <= d[i-1] (or in_data for stage 0) when load[i].
- out_valid = v[DEPTH-1] & clk_en; out_data = d[DEPTH-1]. A transfer occurs iff out_valid & out_ready.
- Latency: into an empty pipe, a word accepted at edge t is presented with out_valid=1 in the cycle after edge t+DEPTH-1, i.e. DEPTH cycles. DEPTH=1 gives a single registered stage.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Stall with out_ready=0: words pack toward the output. in_ready stays 1 until all DEPTH stages are valid; then in_ready=0.
- Full with out_ready=1: simultaneous in/out in the same cycle is allowed; occupancy is unchanged.
- Occupancy: registered; updated by +load[0] - (out_valid & out_ready) each enabled cycle; always equals the popcount of v. Saturation cannot occur by construction; assertions must check 0..DEPTH.
- flush=1 (clk_en=1): next edge sets all v=0 and occupancy=0. If CLEAR_DATA=1, d=0. in_ready=0 in the flush cycle, so no input is accepted. out_valid still reflects the current state, and an out transfer in the flush cycle is legal and counts.
- clk_en=0: no register changes, including flush (flush is ignored). in_ready=0 and out_valid=0.
- Data order is strictly FIFO. There is no duplication or loss except via flush and reset.
- Reset asserted mid-stream: all in-flight words are dropped immediately (async). No output glitch beyond the valid deassertion.

Decomposition:
- Package gpu_pipe_pkg:
  - function occ_width(depth) returning $clog2(depth+1).
  - localparam-style constants for standard lane delays (e.g. RASTER_LAT, SHADE_LAT) used to size instances.
- Sub-module elastic_pipe_stage: one v/d register pair with load/adv inputs and the CLEAR_DATA option, instantiated DEPTH times via generate.
- Top level holds the adv/ready chain and the occupancy counter.

Test Plan:
- Reset/latency: DEPTH=4, WIDTH=8, out_ready=1. Single in_data=0xA5 at cycle 0 -> out_valid=1 with out_data=0xA5 at cycle 4 only; occupancy 1 during cycles 1-4, then 0.
- Streaming: in_data 0..15 back-to-back, out_ready=1 -> outputs 0..15 in consecutive cycles starting at cycle 4; in_ready never drops.
- Backpressure: out_ready=0; offer 0x10,0x11,... -> exactly 4 accepted, then in_ready=0 and occupancy=4. Raise out_ready -> 0x10..0x13 emerge in order, and in_ready=1 in the same cycle out_ready rises.
- Bubble collapse: send 0x01, 2 idle cycles, then 0x02, with out_ready=0 -> both pack into stages 3 and 2, occupancy=2, in_ready=1.
- Flush/clk_en: fill 3 words, assert flush for 1 cycle -> occupancy=0 and out_valid=0 next cycle. Then hold clk_en=0 for 5 cycles with in_valid=1 -> nothing accepted, state unchanged.
- Async reset: assert rst mid-stream with occupancy=3 -> out_valid=0 and occupancy=0 immediately, out_data=0 (CLEAR_DATA=1). Sweep DEPTH=1 and repeat the latency test -> latency 1.
